// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - stall/flush sequencer for the 5-stage pipeline
module hazard_controller #(
   parameter int MDU_LATENCY     = 4,
   parameter int REG_ADDR_WIDTH  = 5,
   parameter int STALL_CNT_WIDTH = 16
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [REG_ADDR_WIDTH-1:0]  rs_d,
   input  logic [REG_ADDR_WIDTH-1:0]  rt_d,
   input  logic                       branch_d,
   input  logic                       branch_taken_d,
   input  logic                       mdu_op_d,
   input  logic                       mdu_read_d,
   input  logic [REG_ADDR_WIDTH-1:0]  write_reg_e,
   input  logic                       reg_write_e,
   input  logic                       mem_to_reg_e,
   input  logic                       mdu_start_e,
   input  logic [REG_ADDR_WIDTH-1:0]  write_reg_m,
   input  logic                       mem_to_reg_m,
   output logic                       fetch_write,
   output logic                       decode_write,
   output logic                       decode_flush,
   output logic                       execute_flush,
   output logic                       mdu_busy,
   output logic [STALL_CNT_WIDTH-1:0] stall_count
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } mdu_state_t;

   localparam logic [3:0] MDU_LOAD = 4'(MDU_LATENCY - 1);

   mdu_state_t state, state_next;
   logic [3:0] mdu_cnt, mdu_cnt_next;

   logic match_e, match_m;
   logic lw_stall, br_stall, mdu_stall, stall;

   // Register 0 is hardwired to zero, so it never produces a dependency.
   assign match_e = (write_reg_e != '0) && ((write_reg_e == rs_d) || (write_reg_e == rt_d));
   assign match_m = (write_reg_m != '0) && ((write_reg_m == rs_d) || (write_reg_m == rt_d));

   assign lw_stall  = mem_to_reg_e && match_e;
   assign br_stall  = branch_d && ((reg_write_e && match_e) || (mem_to_reg_m && match_m));
   assign mdu_stall = (mdu_op_d || mdu_read_d) && mdu_busy;
   assign stall     = lw_stall || br_stall || mdu_stall;

   assign mdu_busy = (state == BUSY);

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         mdu_cnt <= '0;
      end else begin
         state   <= state_next;
         mdu_cnt <= mdu_cnt_next;
      end
   end

   // A start while BUSY is a protocol violation and is deliberately ignored.
   always_comb begin
      state_next   = state;
      mdu_cnt_next = mdu_cnt;
      case (state)
         IDLE: begin
            if (mdu_start_e) begin
               state_next   = BUSY;
               mdu_cnt_next = MDU_LOAD;
            end
         end
         BUSY: begin
            if (mdu_cnt == 4'd1) begin
               state_next   = IDLE;
               mdu_cnt_next = '0;
            end else begin
               mdu_cnt_next = mdu_cnt - 4'd1;
            end
         end
         default: begin
            state_next   = IDLE;
            mdu_cnt_next = '0;
         end
      endcase
   end

   always_comb begin
      fetch_write   = 1'b1;
      decode_write  = 1'b1;
      decode_flush  = 1'b1;
      execute_flush = 1'b1;
      if (!reset) begin
         fetch_write   = !stall;
         decode_write  = !stall;
         decode_flush  = branch_taken_d && !stall;
         execute_flush = stall;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         stall_count <= '0;
      end else if (stall && (stall_count != '1)) begin
         stall_count <= stall_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - self-checking bench for hazard_controller
module tb_hazard_controller;

   localparam int LAT = 4;

   logic       clock = 1'b0;
   logic       reset;
   logic [4:0] rs_d, rt_d, write_reg_e, write_reg_m;
   logic       branch_d, branch_taken_d, mdu_op_d, mdu_read_d;
   logic       reg_write_e, mem_to_reg_e, mdu_start_e, mem_to_reg_m;

   logic        fw_a, dw_a, df_a, ef_a, busy_a;
   logic [15:0] cnt_a;
   logic        fw_b, dw_b, df_b, ef_b, busy_b;
   logic [3:0]  cnt_b;

   int checks = 0;
   int passes = 0;

   // Model state: cycle index, cycle the running MDU op issued in, raw stall total.
   int cyc = 0;
   int issue_cyc = -100;
   int stall_total = 0;
   int viol_count = 0;

   always #5 clock = ~clock;

   hazard_controller #(.MDU_LATENCY(LAT), .REG_ADDR_WIDTH(5), .STALL_CNT_WIDTH(16)) u_dut (
      .clock(clock), .reset(reset), .rs_d(rs_d), .rt_d(rt_d),
      .branch_d(branch_d), .branch_taken_d(branch_taken_d),
      .mdu_op_d(mdu_op_d), .mdu_read_d(mdu_read_d),
      .write_reg_e(write_reg_e), .reg_write_e(reg_write_e),
      .mem_to_reg_e(mem_to_reg_e), .mdu_start_e(mdu_start_e),
      .write_reg_m(write_reg_m), .mem_to_reg_m(mem_to_reg_m),
      .fetch_write(fw_a), .decode_write(dw_a), .decode_flush(df_a),
      .execute_flush(ef_a), .mdu_busy(busy_a), .stall_count(cnt_a)
   );

   hazard_controller #(.MDU_LATENCY(LAT), .REG_ADDR_WIDTH(5), .STALL_CNT_WIDTH(4)) u_sat (
      .clock(clock), .reset(reset), .rs_d(rs_d), .rt_d(rt_d),
      .branch_d(branch_d), .branch_taken_d(branch_taken_d),
      .mdu_op_d(mdu_op_d), .mdu_read_d(mdu_read_d),
      .write_reg_e(write_reg_e), .reg_write_e(reg_write_e),
      .mem_to_reg_e(mem_to_reg_e), .mdu_start_e(mdu_start_e),
      .write_reg_m(write_reg_m), .mem_to_reg_m(mem_to_reg_m),
      .fetch_write(fw_b), .decode_write(dw_b), .decode_flush(df_b),
      .execute_flush(ef_b), .mdu_busy(busy_b), .stall_count(cnt_b)
   );

   function automatic bit m_busy();
      return ((cyc - issue_cyc) >= 1) && ((cyc - issue_cyc) <= LAT - 1);
   endfunction

   function automatic bit m_match(logic [4:0] x);
      return (x != 0) && (x == rs_d || x == rt_d);
   endfunction

   function automatic bit m_stall();
      bit lw, br, md;
      lw = mem_to_reg_e && m_match(write_reg_e);
      br = branch_d && ((reg_write_e && m_match(write_reg_e)) || (mem_to_reg_m && m_match(write_reg_m)));
      md = (mdu_op_d || mdu_read_d) && m_busy();
      return lw || br || md;
   endfunction

   // {fetch_write, decode_write, decode_flush, execute_flush, mdu_busy}
   function automatic logic [4:0] m_ctrl();
      bit s;
      s = m_stall();
      if (reset) return {4'b1111, m_busy()};
      return {!s, !s, branch_taken_d && !s, s, m_busy()};
   endfunction

   function automatic int sat(int v, int max);
      return (v > max) ? max : v;
   endfunction

   task automatic tick();
      bit s, st;
      s  = m_stall();
      st = mdu_start_e && !m_busy();
      if (mdu_start_e && m_busy() && !reset) viol_count++;
      @(posedge clock);
      if (reset) begin
         issue_cyc   = -100;
         stall_total = 0;
      end else begin
         if (s) stall_total++;
         if (st) issue_cyc = cyc;
      end
      cyc++;
      #1;
   endtask

   task automatic clear_inputs();
      rs_d = 0; rt_d = 0; write_reg_e = 0; write_reg_m = 0;
      branch_d = 0; branch_taken_d = 0; mdu_op_d = 0; mdu_read_d = 0;
      reg_write_e = 0; mem_to_reg_e = 0; mdu_start_e = 0; mem_to_reg_m = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1;
      tick();
      reset = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 1;
      tick();
      tick();
      #1;
      checks++;
      if ({fw_a, dw_a, df_a, ef_a, busy_a} !== 5'b11110) $display("FAIL reset_ctrl: got %b expected 11110", {fw_a, dw_a, df_a, ef_a, busy_a});
      else passes++;
      checks++;
      if (cnt_a !== 16'd0 || cnt_b !== 4'd0) $display("FAIL reset_count: got %0d/%0d expected 0/0", cnt_a, cnt_b);
      else passes++;
      reset = 0;
      #1;
      checks++;
      if ({fw_a, dw_a, df_a, ef_a} !== 4'b1100) $display("FAIL idle_ctrl: got %b expected 1100", {fw_a, dw_a, df_a, ef_a});
      else passes++;
   endtask

   task automatic test_load_use();
      do_reset();
      mem_to_reg_e = 1; write_reg_e = 8; rs_d = 8;
      #1;
      checks++;
      if ({fw_a, dw_a, ef_a} !== 3'b001) $display("FAIL load_use_stall: got %b expected 001", {fw_a, dw_a, ef_a});
      else passes++;
      tick();
      checks++;
      if (cnt_a !== 16'd1) $display("FAIL load_use_count: got %0d expected 1", cnt_a);
      else passes++;
      write_reg_e = 0; rs_d = 0;
      #1;
      checks++;
      if ({fw_a, dw_a, ef_a} !== 3'b110) $display("FAIL load_use_reg0: got %b expected 110", {fw_a, dw_a, ef_a});
      else passes++;
   endtask

   task automatic test_branch();
      do_reset();
      branch_d = 1; reg_write_e = 1; write_reg_e = 9; rt_d = 9;
      #1;
      checks++;
      if ({fw_a, ef_a} !== 2'b01) $display("FAIL branch_e_stall: got %b expected 01", {fw_a, ef_a});
      else passes++;
      tick();
      write_reg_e = 0; mem_to_reg_m = 1; write_reg_m = 9;
      #1;
      checks++;
      if ({fw_a, ef_a} !== 2'b01) $display("FAIL branch_m_stall: got %b expected 01", {fw_a, ef_a});
      else passes++;
      branch_taken_d = 1;
      #1;
      checks++;
      if (df_a !== 1'b0) $display("FAIL stalled_branch_flush: got %b expected 0", df_a);
      else passes++;
      tick();
      clear_inputs();
      branch_d = 1; branch_taken_d = 1;
      #1;
      checks++;
      if ({fw_a, df_a, ef_a} !== 3'b110) $display("FAIL branch_taken: got %b expected 110", {fw_a, df_a, ef_a});
      else passes++;
      checks++;
      if (cnt_a !== 16'd2) $display("FAIL branch_count: got %0d expected 2", cnt_a);
      else passes++;
   endtask

   task automatic test_mdu();
      do_reset();
      mdu_start_e = 1;
      tick();
      mdu_start_e = 0; mdu_read_d = 1;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if ({fw_a, ef_a, busy_a} !== ((i < 3) ? 3'b011 : 3'b100))
            $display("FAIL mdu_cycle%0d: got %b expected %b", i, {fw_a, ef_a, busy_a}, (i < 3) ? 3'b011 : 3'b100);
         else passes++;
         tick();
      end
      checks++;
      if (cnt_a !== 16'd3) $display("FAIL mdu_count: got %0d expected 3", cnt_a);
      else passes++;
   endtask

   task automatic test_illegal_restart();
      int v0;
      do_reset();
      v0 = viol_count;
      mdu_start_e = 1;
      tick();
      tick();
      mdu_start_e = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (busy_a !== ((i < 2) ? 1'b1 : 1'b0)) $display("FAIL restart_busy%0d: got %b expected %b", i, busy_a, (i < 2) ? 1'b1 : 1'b0);
         else passes++;
         tick();
      end
      checks++;
      if (viol_count - v0 !== 1) $display("FAIL restart_violation_flag: got %0d expected 1", viol_count - v0);
      else passes++;
   endtask

   task automatic test_reset_mid_op();
      do_reset();
      mdu_start_e = 1;
      tick();
      mdu_start_e = 0; mdu_op_d = 1;
      tick();
      #1;
      checks++;
      if ({busy_a, cnt_a} !== {1'b1, 16'd1}) $display("FAIL midop_before: got %b/%0d expected 1/1", busy_a, cnt_a);
      else passes++;
      reset = 1;
      #1;
      checks++;
      if ({fw_a, dw_a, df_a, ef_a} !== 4'b1111) $display("FAIL midop_reset_ctrl: got %b expected 1111", {fw_a, dw_a, df_a, ef_a});
      else passes++;
      tick();
      reset = 0;
      #1;
      checks++;
      if ({busy_a, cnt_a} !== {1'b0, 16'd0}) $display("FAIL midop_after: got %b/%0d expected 0/0", busy_a, cnt_a);
      else passes++;
   endtask

   task automatic test_saturation();
      do_reset();
      mem_to_reg_e = 1; write_reg_e = 3; rt_d = 3;
      for (int i = 1; i <= 20; i++) begin
         tick();
         checks++;
         if (cnt_b !== 4'(sat(i, 15)) || cnt_a !== 16'(i))
            $display("FAIL saturation%0d: got %0d/%0d expected %0d/%0d", i, cnt_b, cnt_a, sat(i, 15), i);
         else passes++;
      end
   endtask

   task automatic test_random();
      logic [4:0] exp_ctrl;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         reset          = ($urandom_range(0, 39) == 0);
         rs_d           = 5'($urandom_range(0, 3));
         rt_d           = 5'($urandom_range(0, 3));
         write_reg_e    = 5'($urandom_range(0, 3));
         write_reg_m    = 5'($urandom_range(0, 3));
         branch_d       = 1'($urandom_range(0, 1));
         branch_taken_d = 1'($urandom_range(0, 1));
         mdu_op_d       = ($urandom_range(0, 3) == 0);
         mdu_read_d     = ($urandom_range(0, 3) == 0);
         reg_write_e    = 1'($urandom_range(0, 1));
         mem_to_reg_e   = ($urandom_range(0, 2) == 0);
         mem_to_reg_m   = ($urandom_range(0, 2) == 0);
         mdu_start_e    = ($urandom_range(0, 5) == 0);
         #1;
         exp_ctrl = m_ctrl();
         checks++;
         if ({fw_a, dw_a, df_a, ef_a, busy_a} !== exp_ctrl || {fw_b, dw_b, df_b, ef_b, busy_b} !== exp_ctrl)
            $display("FAIL random_ctrl%0d: got %b/%b expected %b", i, {fw_a, dw_a, df_a, ef_a, busy_a}, {fw_b, dw_b, df_b, ef_b, busy_b}, exp_ctrl);
         else passes++;
         checks++;
         if (cnt_a !== 16'(sat(stall_total, 65535)) || cnt_b !== 4'(sat(stall_total, 15)))
            $display("FAIL random_count%0d: got %0d/%0d expected %0d/%0d", i, cnt_a, cnt_b, sat(stall_total, 65535), sat(stall_total, 15));
         else passes++;
         tick();
      end
      reset = 0;
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_branch();
      test_mdu();
      test_illegal_restart();
      test_reset_mid_op();
      test_saturation();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
